exc_sequencer: RTL and testbench

EXC_SEQUENCER -- requirements
Module: exc_sequencer

---
 rtl/exc_sequencer.sv | 130 +++++++++++++
 tb/tb_exc_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_sequencer.sv
// Exception sequencer: picks the highest-priority MEM-stage event, reports it to CP0 for one cycle, then flushes and redirects the pipeline.
// Optional macro EXC_INT_SYNC_EN adds a two-flop synchroniser on int_i (timer_int_i stays unsynchronised).
module exc_sequencer #(
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
   parameter int          FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_req_i,
   input  logic [5:0]  int_i,
   input  logic        timer_int_i,
   input  logic [31:0] status_i,
   input  logic [31:0] epc_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] cur_pc_o,
   output logic        delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

   localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

   state_t      state;
   logic [2:0]  count;
   logic [31:0] target;
   logic [5:0]  int_s;
   logic        int_pending;
   logic        event_now;
   logic        is_eret;
   logic [31:0] code;

`ifdef EXC_INT_SYNC_EN
   logic [5:0] sync1;
   logic [5:0] sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= int_i;
         sync2 <= sync1;
      end
   end

   assign int_s = {sync2[5] | timer_int_i, sync2[4:0]};
`else
   assign int_s = {int_i[5] | timer_int_i, int_i[4:0]};
`endif

   // Interrupts need global enable set and the exception level clear.
   assign int_pending = (|(int_s & status_i[15:10])) && status_i[0] && !status_i[1];
   assign event_now   = exc_valid_i && (int_pending || (|exc_req_i));

   always_comb begin
      code    = 32'h0;
      is_eret = 1'b0;
      if (int_pending)       code = 32'h01;
      else if (exc_req_i[1]) code = 32'h0a;
      else if (exc_req_i[0]) code = 32'h08;
      else if (exc_req_i[2]) code = 32'h0d;
      else if (exc_req_i[3]) code = 32'h0c;
      else if (exc_req_i[4]) begin
         code    = 32'h0e;
         is_eret = 1'b1;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{status_i[31:16], status_i[9:2]};

   // Outputs are registered: they reflect the state being entered at each edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         count        <= '0;
         target       <= '0;
         excepttype_o <= '0;
         cur_pc_o     <= '0;
         delayslot_o  <= 1'b0;
         flush_o      <= 1'b0;
         new_pc_o     <= '0;
         busy_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (event_now) begin
                  state        <= COMMIT;
                  excepttype_o <= code;
                  cur_pc_o     <= pc_i;
                  delayslot_o  <= in_delayslot_i;
                  target       <= is_eret ? epc_i : EXC_VECTOR;
                  busy_o       <= 1'b1;
               end
            end
            COMMIT: begin
               state        <= FLUSH;
               count        <= FLUSH_LAST;
               excepttype_o <= '0;
               cur_pc_o     <= '0;
               delayslot_o  <= 1'b0;
               flush_o      <= 1'b1;
               new_pc_o     <= target;
            end
            FLUSH: begin
               if (count == 3'd0) begin
                  state    <= IDLE;
                  flush_o  <= 1'b0;
                  new_pc_o <= '0;
                  busy_o   <= 1'b0;
               end else begin
                  count <= count - 3'd1;
               end
            end
            default: begin
               state   <= IDLE;
               flush_o <= 1'b0;
               busy_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed testbench for exc_sequencer with default parameters (EXC_VECTOR=0x20, FLUSH_CYCLES=2).
module tb_exc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid_i;
   logic [4:0]  exc_req_i;
   logic [5:0]  int_i;
   logic        timer_int_i;
   logic [31:0] status_i;
   logic [31:0] epc_i;
   logic [31:0] pc_i;
   logic        in_delayslot_i;
   logic [31:0] excepttype_o;
   logic [31:0] cur_pc_o;
   logic        delayslot_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic        busy_o;

   int n_cmp = 0;
   int n_bad = 0;

   exc_sequencer dut (
      .clk(clk), .rst(rst), .exc_valid_i(exc_valid_i), .exc_req_i(exc_req_i),
      .int_i(int_i), .timer_int_i(timer_int_i), .status_i(status_i), .epc_i(epc_i),
      .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .excepttype_o(excepttype_o),
      .cur_pc_o(cur_pc_o), .delayslot_o(delayslot_o), .flush_o(flush_o),
      .new_pc_o(new_pc_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   // Packs every output into one vector: {busy, flush, delayslot, excepttype, cur_pc, new_pc}.
   function automatic logic [98:0] outs();
      return {busy_o, flush_o, delayslot_o, excepttype_o, cur_pc_o, new_pc_o};
   endfunction

   function automatic logic [98:0] expv(input logic b, input logic f, input logic d,
                                        input logic [31:0] c, input logic [31:0] p,
                                        input logic [31:0] n);
      return {b, f, d, c, p, n};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      exc_valid_i    = 1'b0;
      exc_req_i      = '0;
      int_i          = '0;
      timer_int_i    = 1'b0;
      status_i       = '0;
      epc_i          = '0;
      pc_i           = '0;
      in_delayslot_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [98:0] e;
      quiet();
      rst = 1'b1;
      tick();
      tick();
      e = '0;
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL reset: got %h want %h", outs(), e);
      end
      rst = 1'b0;
   endtask

   task automatic test_syscall();
      logic [98:0] e [4];
      e[0] = expv(1, 0, 0, 32'h08, 32'h100, 32'h0);
      e[1] = expv(1, 1, 0, 32'h0, 32'h0, 32'h20);
      e[2] = expv(1, 1, 0, 32'h0, 32'h0, 32'h20);
      e[3] = expv(0, 0, 0, 32'h0, 32'h0, 32'h0);
      exc_valid_i = 1'b1;
      exc_req_i   = 5'b00001;
      pc_i        = 32'h100;
      tick();
      quiet();
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (outs() !== e[i]) begin
            n_bad++;
            $display("[TB] FAIL syscall cycle N+%0d: got %h want %h", i + 1, outs(), e[i]);
         end
         if (i < 3) tick();
      end
   endtask

   task automatic test_eret();
      logic [98:0] e [3];
      e[0] = expv(1, 0, 0, 32'h0e, 32'h200, 32'h0);
      e[1] = expv(1, 1, 0, 32'h0, 32'h0, 32'h400);
      e[2] = expv(1, 1, 0, 32'h0, 32'h0, 32'h400);
      exc_valid_i = 1'b1;
      exc_req_i   = 5'b10000;
      epc_i       = 32'h400;
      pc_i        = 32'h200;
      tick();
      quiet();
      epc_i = 32'h999;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (outs() !== e[i]) begin
            n_bad++;
            $display("[TB] FAIL eret cycle N+%0d: got %h want %h", i + 1, outs(), e[i]);
         end
         tick();
      end
      quiet();
   endtask

   // Interrupt lines are raised two idle cycles early so a synchronised build sees them too.
   task automatic test_priority();
      logic [5:0]  ints [6] = '{6'b000001, 6'b000001, 6'b0, 6'b0, 6'b0, 6'b0};
      logic [31:0] stat [6] = '{32'h401, 32'h403, 32'h0, 32'h0, 32'h0, 32'h0};
      logic [4:0]  reqs [6] = '{5'b01010, 5'b01010, 5'b00101, 5'b01100, 5'b11000, 5'b11111};
      logic [31:0] codes[6] = '{32'h01, 32'h0a, 32'h08, 32'h0d, 32'h0c, 32'h0a};
      logic [98:0] e;
      for (int i = 0; i < 6; i++) begin
         int_i    = ints[i];
         status_i = stat[i];
         pc_i     = 32'h300 + 32'(i * 4);
         exc_req_i = reqs[i];
         tick();
         tick();
         e = '0;
         n_cmp++;
         if (outs() !== e) begin
            n_bad++;
            $display("[TB] FAIL no_valid case %0d: got %h want %h", i, outs(), e);
         end
         exc_valid_i = 1'b1;
         tick();
         exc_valid_i = 1'b0;
         e = expv(1, 0, 0, codes[i], 32'h300 + 32'(i * 4), 32'h0);
         n_cmp++;
         if (outs() !== e) begin
            n_bad++;
            $display("[TB] FAIL priority case %0d: got %h want %h", i, outs(), e);
         end
         quiet();
         tick();
         tick();
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [98:0] e;
      exc_valid_i = 1'b1;
      exc_req_i   = 5'b00001;
      pc_i        = 32'h500;
      tick();
      exc_req_i   = 5'b00100;
      pc_i        = 32'h504;
      tick();
      tick();
      e = expv(1, 1, 0, 32'h0, 32'h0, 32'h20);
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL trap_ignored_in_flush: got %h want %h", outs(), e);
      end
      tick();
      e = '0;
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL first_idle: got %h want %h", outs(), e);
      end
      tick();
      e = expv(1, 0, 0, 32'h0d, 32'h504, 32'h0);
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL back_to_back_trap: got %h want %h", outs(), e);
      end
      quiet();
      tick();
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      logic [98:0] e;
      exc_valid_i = 1'b1;
      exc_req_i   = 5'b00001;
      pc_i        = 32'h600;
      tick();
      quiet();
      tick();
      rst = 1'b1;
      tick();
      e = '0;
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL reset_mid_flush: got %h want %h", outs(), e);
      end
      rst         = 1'b0;
      exc_valid_i = 1'b1;
      exc_req_i   = 5'b00001;
      pc_i        = 32'h604;
      tick();
      quiet();
      e = expv(1, 0, 0, 32'h08, 32'h604, 32'h0);
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL after_reset_event: got %h want %h", outs(), e);
      end
      tick();
      e = expv(1, 1, 0, 32'h0, 32'h0, 32'h20);
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL after_reset_flush: got %h want %h", outs(), e);
      end
      tick();
      tick();
   endtask

   task automatic test_timer();
      logic [98:0] e;
      timer_int_i    = 1'b1;
      status_i       = 32'h0000_8001;
      in_delayslot_i = 1'b1;
      pc_i           = 32'h700;
      exc_valid_i    = 1'b1;
      tick();
      quiet();
      e = expv(1, 0, 1, 32'h01, 32'h700, 32'h0);
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL timer_commit: got %h want %h", outs(), e);
      end
      tick();
      e = expv(1, 1, 0, 32'h0, 32'h0, 32'h20);
      n_cmp++;
      if (outs() !== e) begin
         n_bad++;
         $display("[TB] FAIL timer_flush: got %h want %h", outs(), e);
      end
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_syscall();
      test_eret();
      test_priority();
      test_back_to_back();
      test_reset_mid();
      test_timer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
